// File: rtl/aes_fe_pkg.sv
// Shared encodings, FSM state type and sizing helper for the AES stream front end.
package aes_fe_pkg;

  localparam logic [1:0] MODE_ENC = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_KEY = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_KEY_WAIT,
    S_DATA
  } fe_state_e;

  function automatic int unsigned words_per(input int unsigned bits, input int unsigned in_w);
    return bits / in_w;
  endfunction

endpackage

// File: rtl/aes_fe_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; DEPTH must be a power of 2.
module aes_fe_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_wr,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_rd,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A write while full is allowed only when a read frees the head slot in the same cycle.
  assign w_wr = i_wr & (~o_full | i_rd);
  assign w_rd = i_rd & ~o_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/aes_stream_frontend.sv
// Word-stream framing in front of an AES round core: key/block assembly, credit-based
// block issue and result serialisation.
module aes_stream_frontend
  import aes_fe_pkg::*;
#(
  parameter int unsigned IN_W       = 128,
  parameter int unsigned KEY_BITS   = 256,
  parameter int unsigned BLK_W      = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RES_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [1:0]          i_in_mode,
  input  logic [IN_W-1:0]     i_in_data,
  output logic                o_key_valid,
  input  logic                i_key_ready,
  output logic [KEY_BITS-1:0] o_key_data,
  output logic                o_core_valid,
  input  logic                i_core_ready,
  output logic                o_core_dec,
  output logic [BLK_W-1:0]    o_core_data,
  input  logic                i_res_valid,
  input  logic [BLK_W-1:0]    i_res_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [IN_W-1:0]     o_out_data,
  output logic                o_out_last,
  output logic                o_err_frag,
  output logic                o_err_mode,
  output logic                o_err_nokey
);

  localparam int unsigned KW  = words_per(KEY_BITS, IN_W);
  localparam int unsigned BW  = words_per(BLK_W, IN_W);
  localparam int unsigned KCW = $clog2(KW + 1);
  localparam int unsigned BCW = $clog2(BW + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RCW = $clog2(RES_DEPTH + 1);
  localparam int unsigned OCW = $clog2(RES_DEPTH + 1);

  if ((KEY_BITS % IN_W) != 0) begin : g_bad_key
    $error("KEY_BITS must be a multiple of IN_W");
  end
  if (!(IN_W == 32 || IN_W == 64 || IN_W == 128) || BLK_W != 128) begin : g_bad_width
    $error("IN_W must be 32, 64 or 128 and BLK_W must be 128");
  end

  fe_state_e           r_state;
  logic [KEY_BITS-1:0] r_key;
  logic [KCW-1:0]      r_kcnt;
  logic [BLK_W-1:0]    r_blk;
  logic [BCW-1:0]      r_bcnt;
  logic                r_dec;
  logic                r_key_loaded;
  logic                r_key_valid;
  logic                r_err_frag;
  logic                r_err_mode;
  logic                r_err_nokey;
  logic                r_live;
  logic [OCW-1:0]      r_outst;
  logic                r_core_valid;
  logic                r_ser_act;
  logic [BCW-1:0]      r_ser_cnt;
  logic [BLK_W-1:0]    r_ser_data;

  logic                w_is_key, w_is_ill, w_is_data, w_cont_data, w_data_ok;
  logic                w_would_push, w_drained, w_in_ready, w_acc, w_push;
  logic [BCW-1:0]      w_slot;
  logic [KCW-1:0]      w_kslot;
  logic [BLK_W-1:0]    w_push_blk;
  logic [BLK_W:0]      w_blk_head;
  logic                w_blk_full, w_blk_empty, w_blk_pop;
  logic [FCW-1:0]      w_blk_count, w_blk_cnt_n;
  logic [BLK_W-1:0]    w_res_head;
  logic                w_res_full, w_res_empty, w_res_pop;
  logic [RCW-1:0]      w_res_count, w_res_cnt_n;
  logic [OCW-1:0]      w_outst_n;
  logic                w_credit_ok, w_ser_last, w_ser_free;

  assign w_is_key    = (i_in_mode == MODE_KEY);
  assign w_is_ill    = (i_in_mode == MODE_ILL);
  assign w_is_data   = ~i_in_mode[1];
  assign w_cont_data = (r_state == S_DATA) && w_is_data && (i_in_mode[0] == r_dec);
  assign w_data_ok   = w_is_data && (w_cont_data || r_key_loaded);
  assign w_slot      = w_cont_data ? r_bcnt : '0;
  assign w_kslot     = (r_state == S_KEY) ? r_kcnt : '0;
  assign w_would_push = w_data_ok && (w_slot == BCW'(BW - 1));
  assign w_drained   = w_blk_empty && (r_outst == '0);

  // Key words wait in S_IDLE until every queued block has come back under the old key.
  assign w_in_ready = r_live && (r_state != S_KEY_WAIT) && !(w_would_push && w_blk_full) &&
                      !((r_state == S_IDLE) && w_is_key && !w_drained);
  assign w_acc      = i_in_valid && w_in_ready;
  assign w_push     = w_acc && w_would_push;

  always_comb begin
    w_push_blk = r_blk;
    w_push_blk[int'(w_slot)*IN_W +: IN_W] = i_in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_kcnt       <= '0;
      r_blk        <= '0;
      r_bcnt       <= '0;
      r_dec        <= 1'b0;
      r_key_loaded <= 1'b0;
      r_key_valid  <= 1'b0;
      r_err_frag   <= 1'b0;
      r_err_mode   <= 1'b0;
      r_err_nokey  <= 1'b0;
      r_live       <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_err_frag  <= 1'b0;
      r_err_mode  <= 1'b0;
      r_err_nokey <= 1'b0;
      if (r_state == S_KEY_WAIT) begin
        if (r_key_valid && i_key_ready) begin
          r_key_valid  <= 1'b0;
          r_key_loaded <= 1'b1;
          r_state      <= S_IDLE;
        end else if (!r_key_valid && w_drained) begin
          r_key_valid <= 1'b1;
        end
      end else if (w_acc) begin
        if (w_is_ill) begin
          r_err_mode <= 1'b1;
        end else if (w_is_key) begin
          r_key[int'(w_kslot)*IN_W +: IN_W] <= i_in_data;
          if (r_state == S_DATA) r_err_frag <= 1'b1;
          if (w_kslot == KCW'(KW - 1)) begin
            r_state <= S_KEY_WAIT;
          end else begin
            r_state <= S_KEY;
            r_kcnt  <= w_kslot + KCW'(1);
          end
        end else begin
          if ((r_state == S_KEY) || ((r_state == S_DATA) && !w_cont_data)) r_err_frag <= 1'b1;
          if (!w_data_ok) begin
            r_err_nokey <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_blk <= w_push_blk;
            r_dec <= i_in_mode[0];
            if (w_would_push) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bcnt  <= w_slot + BCW'(1);
            end
          end
        end
      end
    end
  end

  aes_fe_fifo #(
    .WIDTH(BLK_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_blk_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_wr   (w_push),
    .i_wdata({i_in_mode[0], w_push_blk}),
    .i_rd   (w_blk_pop),
    .o_rdata(w_blk_head),
    .o_full (w_blk_full),
    .o_empty(w_blk_empty),
    .o_count(w_blk_count)
  );

  aes_fe_fifo #(
    .WIDTH(BLK_W),
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_wr   (i_res_valid),
    .i_wdata(i_res_data),
    .i_rd   (w_res_pop),
    .o_rdata(w_res_head),
    .o_full (w_res_full),
    .o_empty(w_res_empty),
    .o_count(w_res_count)
  );

  // Issue valid is computed from next-cycle occupancy so it can be registered without a bubble.
  always_comb begin
    w_blk_pop   = r_core_valid && i_core_ready;
    w_blk_cnt_n = w_blk_count + FCW'(w_push) - FCW'(w_blk_pop);
    w_outst_n   = r_outst + OCW'(w_blk_pop) - OCW'(i_res_valid);
    w_res_cnt_n = w_res_count + RCW'(i_res_valid) - RCW'(w_res_pop);
    w_credit_ok = (32'(w_outst_n) + 32'(w_res_cnt_n)) < RES_DEPTH;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outst      <= '0;
      r_core_valid <= 1'b0;
    end else begin
      r_outst      <= w_outst_n;
      r_core_valid <= (w_blk_cnt_n != '0) && w_credit_ok;
    end
  end

  assign w_ser_last = (r_ser_cnt == BCW'(BW - 1));
  assign w_ser_free = !r_ser_act || (i_out_ready && w_ser_last);
  assign w_res_pop  = w_ser_free && !w_res_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ser_act  <= 1'b0;
      r_ser_cnt  <= '0;
      r_ser_data <= '0;
    end else if (w_res_pop) begin
      r_ser_act  <= 1'b1;
      r_ser_cnt  <= '0;
      r_ser_data <= w_res_head;
    end else if (r_ser_act && i_out_ready) begin
      if (w_ser_last) r_ser_act <= 1'b0;
      else            r_ser_cnt <= r_ser_cnt + BCW'(1);
    end
  end

  res_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(i_res_valid && w_res_full && !w_res_pop));

  assign o_in_ready   = w_in_ready;
  assign o_key_valid  = r_key_valid;
  assign o_key_data   = r_key;
  assign o_core_valid = r_core_valid;
  assign o_core_dec   = w_blk_head[BLK_W];
  assign o_core_data  = w_blk_head[BLK_W-1:0];
  assign o_out_valid  = r_ser_act;
  assign o_out_data   = r_ser_data[int'(r_ser_cnt)*IN_W +: IN_W];
  assign o_out_last   = r_ser_act && w_ser_last;
  assign o_err_frag   = r_err_frag;
  assign o_err_mode   = r_err_mode;
  assign o_err_nokey  = r_err_nokey;

endmodule

// File: doc/aes_stream_frontend.md
Name: aes_stream_frontend

Overview:
Parametrised input/output framing controller placed in front of an AES round core.
- Accepts a word stream tagged with a mode (key load / encrypt / decrypt).
- Assembles 128..256-bit keys and 128-bit blocks from IN_W-bit words, queues blocks in a FIFO and issues them to the core under credit flow control.
- Buffers core results and serialises them back to IN_W-bit words.
- Generalises the fixed 128-bit, 256-bit-key device interface to variable word width, key size and queue depth.

Parameters:
- IN_W, 128: stream word width. Legal values: 32, 64, 128.
- KEY_BITS, 256: key size. Legal values: 128, 192, 256. KEY_BITS % IN_W must be 0; elaboration error otherwise.
- BLK_W, 128: AES block width. Fixed; not to be overridden.
- FIFO_DEPTH, 4: input block FIFO depth. Power of 2, ≥2.
- RES_DEPTH, 4: result FIFO depth. Power of 2, ≥2.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_mode  in  2  2'b10 key, 2'b00 encrypt, 2'b01 decrypt, 2'b11 illegal
- in_data  in  IN_W  input word
- key_valid  out  1  assembled key presented to key expander
- key_ready  in  1  key expander accepts key
- key_data  out  KEY_BITS  assembled key
- core_valid  out  1  block issue to core
- core_ready  in  1  core accepts block
- core_dec  out  1  1 = decrypt block
- core_data  out  BLK_W  block to core
- res_valid  in  1  core result strobe; no backpressure toward core
- res_data  in  BLK_W  core result
- out_valid  out  1  output word valid
- out_ready  in  1  output word consumed
- out_data  out  IN_W  output word
- out_last  out  1  final word of a block
- err_frag  out  1  one-cycle pulse: partial block or key dropped
- err_mode  out  1  one-cycle pulse: illegal mode word dropped
- err_nokey  out  1  one-cycle pulse: data word dropped because no key is loaded

Behaviour:
- Reset (async, resetn=0): all outputs 0, FIFOs empty, word counters 0, key_loaded=0, outstanding=0, FSM=S_IDLE.
- Word order: the first word of a key or block occupies bits [IN_W-1:0]; each subsequent word occupies the next higher slice.
- Input FSM states and transitions:
  - S_IDLE: mode 10 → S_KEY. Mode 00/01 with key_loaded → S_DATA. Mode 00/01 without key_loaded → word dropped, err_nokey.
  - S_KEY: collects KEY_BITS/IN_W words. On the last word → S_KEY_WAIT.
  - S_KEY_WAIT: in_ready=0. Waits until the block FIFO is empty and outstanding==0, then asserts key_valid with key_data stable until key_ready. On handshake: key_loaded=1, → S_IDLE.
  - S_DATA: collects BLK_W/IN_W words under a latched mode. On the last word, pushes {dec, block} into the block FIFO, → S_IDLE; when BLK_W==IN_W the push happens in the accepting cycle.
- Mode change mid-assembly (key or block): partial assembly discarded, err_frag pulse. The new word is accepted and starts a fresh assembly in the same cycle.
- in_mode 11: word accepted and dropped, err_mode pulse, FSM state unchanged.
- in_ready = 0 when:
  - FSM is in S_KEY_WAIT, or
  - S_DATA is on its last word and the block FIFO is full, or
  - a key word arrives in S_IDLE while the FIFO is non-empty or outstanding≠0. Key words are held off until the pipeline has drained.
- Core issue:
  - core_valid = FIFO non-empty AND credit>0, where credit = RES_DEPTH − outstanding − res_fifo_count.
  - Pop on core_valid & core_ready; outstanding++ on issue.
  - Outputs registered: data appears the cycle after the FIFO becomes non-empty.
- Results:
  - res_valid pushes into the result FIFO, outstanding−−.
  - Simultaneous issue and result in one cycle: outstanding unchanged.
  - The credit rule guarantees the result FIFO never overflows. An overflow, if it occurs, is an assertion failure in simulation.
- Serialiser:
  - Emits BLK_W/IN_W words per result, LSB slice first. out_last on the final word.
  - Holds out_data stable while out_valid & !out_ready.
  - Back-to-back blocks with no bubble.
- Throughput: one word per cycle in, one word per cycle out, one block per cycle to the core.
- A key reload after data blocks requires a full drain; blocks already queued use the old key.
- Reset mid-operation: everything aborts immediately; key_loaded cleared; in-flight results are lost.

Decomposition:
- Package aes_fe_pkg holds:
  - mode encodings MODE_KEY=2'b10, MODE_ENC=2'b00, MODE_DEC=2'b01;
  - the FSM state enum;
  - the function words_per(bits) returning bits/IN_W.
- One sub-module, aes_fe_fifo (parametrised width/depth synchronous FIFO with full/empty/count), instantiated twice: block FIFO (BLK_W+1 bits) and result FIFO (BLK_W bits).

Test Plan:
1. IN_W=128, KEY_BITS=256: send 0f0e..00 then 1f1e..10 in mode 10 → key_valid with key_data=256'h1f1e1d..0100 (LSB-first), held until key_ready.
2. After the key, encrypt block ffeeddccbbaa99887766554433221100 with a bench core model returning 8ea2b7ca516745bfeafc49904b496089 (byte order as core) → core_dec=0, identical out_data, out_last=1.
3. IN_W=32: 8 key words, then 4 data words 11111111..44444444 → core_data=128'h44444444333333332222222211111111. Result returned as 4 words, out_last on the 4th only.
4. Data in mode 00 before any key → in_ready=1, err_nokey pulses per word, no core_valid.
5. IN_W=32: two data words in mode 00, then a mode-01 word → err_frag pulse, the partial block is dropped, and the next 3 words complete a decrypt block (core_dec=1).
6. core_ready=1, res_valid withheld, out_ready=0, FIFO_DEPTH=RES_DEPTH=4: push 10 blocks → exactly 4 issued (credit 0), block FIFO fills to 4, and in_ready drops on the last word of block 9. No result overflow.
